// File: rtl/reg4_serial_deser_pkg.sv
// Shared constants and helpers for the reg4 serial deserialiser.
// MODO encodings, DIR constants, a ceil-log2 helper and a parity helper.
package reg4_pkg;

    localparam logic [1:0] MODO_SHIFT  = 2'b00;
    localparam logic [1:0] MODO_ROTATE = 2'b01;
    localparam logic [1:0] MODO_LOAD   = 2'b10;
    localparam logic [1:0] MODO_HOLD   = 2'b11;

    localparam logic DIR_MSB = 1'b1;
    localparam logic DIR_LSB = 1'b0;

    // Ceil(log2(value)); value is expected to be >= 2.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Even-parity bit over up to 16 data bits.
    function automatic logic parity16(input logic [15:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/reg4_serial_deser_fifo.sv
// Synchronous FIFO for assembled words, with a registered head-of-queue output.
module deser_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DW-1:0]                   din,
    output logic [DW-1:0]                   dout,
    output logic [reg4_pkg::clog2(DEPTH):0] count,
    output logic                            full,
    output logic                            empty
);
    import reg4_pkg::*;

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wrPtr_r;
    logic [AW-1:0] rdPtr_r;
    logic [CW-1:0] count_r;
    logic [DW-1:0] dout_r;
    logic          full_r;
    logic          empty_r;

    logic          pushOk_s;
    logic          popOk_s;
    logic [AW-1:0] rdPtrInc_s;
    logic [CW-1:0] countNext_s;
    logic [DW-1:0] headNext_s;

    // Accepted push/pop, next occupancy and the word that will sit at the head.
    always_comb begin
        popOk_s     = pop && !empty_r;
        pushOk_s    = push && (!full_r || popOk_s);
        rdPtrInc_s  = rdPtr_r + AW'(1);
        countNext_s = count_r;
        headNext_s  = dout_r;
        case ({pushOk_s, popOk_s})
            2'b10:   countNext_s = count_r + CW'(1);
            2'b01:   countNext_s = count_r - CW'(1);
            default: countNext_s = count_r;
        endcase
        if (popOk_s) begin
            if (count_r == CW'(1)) begin
                if (pushOk_s) begin
                    headNext_s = din;
                end else begin
                    headNext_s = dout_r;
                end
            end else begin
                headNext_s = mem_r[rdPtrInc_s];
            end
        end else if (empty_r) begin
            if (pushOk_s) begin
                headNext_s = din;
            end else begin
                headNext_s = dout_r;
            end
        end else begin
            headNext_s = dout_r;
        end
    end

    // Storage array; written only on an accepted push.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (pushOk_s) begin
            mem_r[wrPtr_r] <= din;
        end
    end

    // Pointers, occupancy flags and the registered head word.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            dout_r  <= {DW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (pushOk_s) begin
                wrPtr_r <= wrPtr_r + AW'(1);
            end
            if (popOk_s) begin
                rdPtr_r <= rdPtrInc_s;
            end
            count_r <= countNext_s;
            dout_r  <= headNext_s;
            full_r  <= (countNext_s == CW'(DEPTH));
            empty_r <= (countNext_s == {CW{1'b0}});
        end
    end

    assign dout  = dout_r;
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/reg4_serial_deser.sv
// Deserialiser for the reg4 shift register's S_OUT stream: assembles words, queues them, flags drops.
// Build option REG4_DESER_PARITY_EN adds a trailing even-parity bit per word and the PERR output.
module reg4_serial_deser #(
    parameter int         WIDTH      = 8,
    parameter int         DEPTH      = 4,
    parameter logic [1:0] MODO_SHIFT = reg4_pkg::MODO_SHIFT
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            ENB,
    input  logic [1:0]                      MODO,
    input  logic                            DIR,
    input  logic                            S_OUT,
    input  logic                            CLR,
    input  logic                            READY,
    output logic                            VALID,
    output logic [WIDTH-1:0]                Q_WORD,
    output logic [reg4_pkg::clog2(DEPTH):0] COUNT,
`ifdef REG4_DESER_PARITY_EN
    output logic                            PERR,
`endif
    output logic                            OVF
);

`ifdef REG4_DESER_PARITY_EN
    localparam int LAST_IDX = WIDTH;
    localparam int DW       = WIDTH + 1;
`else
    localparam int LAST_IDX = WIDTH - 1;
    localparam int DW       = WIDTH;
`endif
    localparam int CNTW = reg4_pkg::clog2(WIDTH + 1);
    localparam int CW   = reg4_pkg::clog2(DEPTH) + 1;

    logic [CNTW-1:0]  bitCnt_r;
    logic [WIDTH-1:0] word_r;
    logic             dirLat_r;
    logic             ovf_r;

    logic             sample_s;
    logic             lastBit_s;
    logic             dirEff_s;
    logic             push_s;
    logic [WIDTH-1:0] shifted_s;
    logic [DW-1:0]    pushData_s;
    logic [DW-1:0]    head_s;
    logic [CW-1:0]    count_s;
    logic             full_s;
    logic             empty_s;

    // Sample qualification, effective bit order and the word to push.
    always_comb begin
        sample_s  = ENB && (MODO == MODO_SHIFT);
        lastBit_s = (bitCnt_r == CNTW'(LAST_IDX));
        if (bitCnt_r == {CNTW{1'b0}}) begin
            dirEff_s = DIR;
        end else begin
            dirEff_s = dirLat_r;
        end
        if (dirEff_s == reg4_pkg::DIR_MSB) begin
            shifted_s = {word_r[WIDTH-2:0], S_OUT};
        end else begin
            shifted_s = {S_OUT, word_r[WIDTH-1:1]};
        end
        push_s = sample_s && lastBit_s && !CLR;
`ifdef REG4_DESER_PARITY_EN
        // The final sample is the parity bit; the data word is already complete.
        pushData_s = {(reg4_pkg::parity16(16'(word_r)) ^ S_OUT), word_r};
`else
        pushData_s = shifted_s;
`endif
    end

    // Bit counter, partial word and per-word direction latch.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bitCnt_r <= {CNTW{1'b0}};
            word_r   <= {WIDTH{1'b0}};
            dirLat_r <= reg4_pkg::DIR_LSB;
        end else if (CLR) begin
            bitCnt_r <= {CNTW{1'b0}};
            word_r   <= {WIDTH{1'b0}};
        end else if (sample_s) begin
            if (bitCnt_r == {CNTW{1'b0}}) begin
                dirLat_r <= DIR;
            end
            if (lastBit_s) begin
                bitCnt_r <= {CNTW{1'b0}};
                word_r   <= {WIDTH{1'b0}};
            end else begin
                bitCnt_r <= bitCnt_r + CNTW'(1);
                word_r   <= shifted_s;
            end
        end
    end

    // Sticky overflow: a completed word met a full FIFO that was not popping.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ovf_r <= 1'b0;
        end else if (CLR) begin
            ovf_r <= 1'b0;
        end else if (push_s && full_s && !READY) begin
            ovf_r <= 1'b1;
        end
    end

    deser_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push_s),
        .pop   (READY),
        .din   (pushData_s),
        .dout  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign VALID  = !empty_s;
    assign Q_WORD = head_s[WIDTH-1:0];
    assign COUNT  = count_s;
    assign OVF    = ovf_r;
`ifdef REG4_DESER_PARITY_EN
    assign PERR   = head_s[WIDTH];
`endif

endmodule

// File: tb/tb_reg4_serial_deser.sv
// Self-checking bench for reg4_serial_deser: directed scenarios plus a randomized run against a queue model.
module tb_reg4_serial_deser;

`ifdef REG4_DESER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       ENB = 1'b0;
    logic [1:0] MODO = 2'b11;
    logic       DIR = 1'b0;
    logic       S_OUT = 1'b0;
    logic       CLR = 1'b0;
    logic       READY = 1'b0;
    logic       VALID;
    logic [7:0] Q_WORD;
    logic [2:0] COUNT;
    logic       OVF;
`ifdef REG4_DESER_PARITY_EN
    logic       PERR;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: bits of the word in progress, queue of stored words.
    int         mBits[$];
    logic       mDir = 1'b0;
    logic [7:0] mQ[$];
    logic       mP[$];
    logic       mOvf = 1'b0;

    reg4_serial_deser #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .MODO(MODO), .DIR(DIR), .S_OUT(S_OUT),
        .CLR(CLR), .READY(READY), .VALID(VALID), .Q_WORD(Q_WORD), .COUNT(COUNT),
`ifdef REG4_DESER_PARITY_EN
        .PERR(PERR),
`endif
        .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic modelEdge();
        logic       popNow;
        logic       pushNow;
        logic [7:0] w;
        logic       pe;
        popNow  = READY && (mQ.size() > 0);
        pushNow = 1'b0;
        w       = 8'h00;
        pe      = 1'b0;
        if (!RST_N) begin
            mQ.delete(); mP.delete(); mBits.delete(); mOvf = 1'b0;
            return;
        end
        if (ENB && MODO == 2'b00 && !CLR) begin
            if (mBits.size() == 0) mDir = DIR;
            mBits.push_back(int'(S_OUT));
            if (mBits.size() == NB) begin
                for (int i = 0; i < 8; i++) begin
                    if (mDir) w = w + 8'((mBits[i]) << (7 - i));
                    else      w = w + 8'((mBits[i]) << i);
                end
                if (NB == 9) pe = ((^w) != mBits[NB-1][0]);
                pushNow = 1'b1;
                mBits.delete();
            end
        end
        if (CLR) mBits.delete();
        if (popNow) begin
            void'(mQ.pop_front());
            void'(mP.pop_front());
        end
        if (pushNow) begin
            if (mQ.size() < DEPTH) begin
                mQ.push_back(w);
                mP.push_back(pe);
            end else begin
                mOvf = 1'b1;
            end
        end
        if (CLR) mOvf = 1'b0;
    endtask

    task automatic drive(input logic rst, input logic enb, input logic [1:0] modo,
                         input logic dir, input logic sout, input logic clr, input logic rdy);
        RST_N = rst; ENB = enb; MODO = modo; DIR = dir; S_OUT = sout; CLR = clr; READY = rdy;
        @(posedge CLK);
        modelEdge();
        #1;
    endtask

    // Shift one word out; badPar inverts the parity bit; rdyLast raises READY on the final bit.
    task automatic sendWord(input logic [7:0] w, input logic dir, input logic rdyLast, input logic badPar);
        logic b;
        for (int i = 0; i < NB; i++) begin
            if (i == 8)   b = (^w) ^ badPar;
            else if (dir) b = w[7 - i];
            else          b = w[i];
            drive(1'b1, 1'b1, 2'b00, dir, b, 1'b0, (i == NB - 1) ? rdyLast : 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (VALID !== 1'b0 || Q_WORD !== 8'h00 || COUNT !== 3'd0 || OVF !== 1'b0) begin
            failures++;
            $display("FAIL reset: VALID=%b Q_WORD=%h COUNT=%0d OVF=%b required 0/00/0/0", VALID, Q_WORD, COUNT, OVF);
        end
`ifdef REG4_DESER_PARITY_EN
        checks++;
        if (PERR !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b required 0", PERR); end
`endif
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hC0;
        for (int i = 0; i < NB - 1; i++)
            drive(1'b1, 1'b1, 2'b00, 1'b1, (i < 8) ? w[7 - i] : 1'b0, 1'b0, 1'b0);
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("FAIL msb_early_valid: got %b required 0", VALID); end
        drive(1'b1, 1'b1, 2'b00, 1'b1, (NB == 9) ? 1'b0 : w[0], 1'b0, 1'b0);
        checks++;
        if (VALID !== 1'b1 || Q_WORD !== 8'hC0 || COUNT !== 3'd1) begin
            failures++;
            $display("FAIL msb_word: VALID=%b Q_WORD=%h COUNT=%0d required 1/c0/1", VALID, Q_WORD, COUNT);
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (VALID !== 1'b0 || COUNT !== 3'd0) begin
            failures++; $display("FAIL msb_pop: VALID=%b COUNT=%0d required 0/0", VALID, COUNT);
        end
    endtask

    task automatic test_lsb_dir_toggle();
        logic [7:0] w;
        w = 8'hC0;
        sendWord(8'h03, 1'b0, 1'b0, 1'b0);
        // Same bit stream, but DIR flips to MSB after the third bit.
        for (int i = 0; i < NB; i++)
            drive(1'b1, 1'b1, 2'b00, (i >= 3), (i < 8) ? w[7 - i] : 1'b0, 1'b0, 1'b0);
        checks++;
        if (COUNT !== 3'd2 || Q_WORD !== 8'h03) begin
            failures++; $display("FAIL lsb_word: Q_WORD=%h COUNT=%0d required 03/2", Q_WORD, COUNT);
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (VALID !== 1'b1 || Q_WORD !== 8'h03) begin
            failures++; $display("FAIL lsb_dir_toggle: VALID=%b Q_WORD=%h required 1/03", VALID, Q_WORD);
        end
        drain();
    endtask

    task automatic test_qualifier();
        logic [7:0] w;
        logic       b;
        int         q;
        w = 8'h00;
        q = 0;
        for (int c = 0; c < 2 * NB; c++) begin
            b = 1'($urandom_range(0, 1));
            if (c % 2 == 0) begin
                if (q < 8) w = 8'(w * 2 + b);
                q++;
                drive(1'b1, 1'b1, 2'b00, 1'b1, b, 1'b0, 1'b0);
            end else if (c % 4 == 1) begin
                drive(1'b1, 1'b0, 2'b00, 1'b1, ~b, 1'b0, 1'b0);
            end else begin
                drive(1'b1, 1'b1, 2'b01, 1'b0, ~b, 1'b0, 1'b0);
            end
        end
        checks++;
        if (COUNT !== 3'd1 || Q_WORD !== w) begin
            failures++; $display("FAIL qualifier: Q_WORD=%h COUNT=%0d required %h/1", Q_WORD, COUNT, w);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] ws[5];
        for (int i = 0; i < 5; i++) begin
            ws[i] = 8'($urandom);
            sendWord(ws[i], 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (COUNT !== 3'd4 || OVF !== 1'b1) begin
            failures++; $display("FAIL ovf_full: COUNT=%0d OVF=%b required 4/1", COUNT, OVF);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (VALID !== 1'b1 || Q_WORD !== ws[i]) begin
                failures++; $display("FAIL ovf_order%0d: VALID=%b Q_WORD=%h required 1/%h", i, VALID, Q_WORD, ws[i]);
            end
            drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (VALID !== 1'b0 || COUNT !== 3'd0 || OVF !== 1'b1) begin
            failures++; $display("FAIL ovf_drained: VALID=%b COUNT=%0d OVF=%b required 0/0/1", VALID, COUNT, OVF);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] ws[5];
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (OVF !== 1'b0) begin failures++; $display("FAIL clr_ovf: got %b required 0", OVF); end
        for (int i = 0; i < 5; i++) begin
            ws[i] = 8'($urandom);
            sendWord(ws[i], 1'b1, (i == 4), 1'b0);
        end
        checks++;
        if (COUNT !== 3'd4 || OVF !== 1'b0 || Q_WORD !== ws[1]) begin
            failures++;
            $display("FAIL full_push_pop: COUNT=%0d OVF=%b Q_WORD=%h required 4/0/%h", COUNT, OVF, Q_WORD, ws[1]);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (Q_WORD !== ws[i]) begin
                failures++; $display("FAIL full_order%0d: Q_WORD=%h required %h", i, Q_WORD, ws[i]);
            end
            drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'b00, 1'b1, 1'($urandom), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        sendWord(8'hA5, 1'b1, 1'b0, 1'b0);
        checks++;
        if (VALID !== 1'b1 || Q_WORD !== 8'hA5 || COUNT !== 3'd1) begin
            failures++; $display("FAIL clr_partial: VALID=%b Q_WORD=%h COUNT=%0d required 1/a5/1", VALID, Q_WORD, COUNT);
        end
        drain();
        // CLR on the completing sample discards the word.
        for (int i = 0; i < NB - 1; i++) drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (VALID !== 1'b0 || COUNT !== 3'd0) begin
            failures++; $display("FAIL clr_push: VALID=%b COUNT=%0d required 0/0", VALID, COUNT);
        end
    endtask

    task automatic test_reset_midword();
        sendWord(8'h5A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (VALID !== 1'b0 || Q_WORD !== 8'h00 || COUNT !== 3'd0 || OVF !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: VALID=%b Q_WORD=%h COUNT=%0d OVF=%b required 0/00/0/0", VALID, Q_WORD, COUNT, OVF);
        end
        sendWord(8'hA5, 1'b1, 1'b0, 1'b0);
        checks++;
        if (Q_WORD !== 8'hA5 || COUNT !== 3'd1) begin
            failures++; $display("FAIL reset_mid_word: Q_WORD=%h COUNT=%0d required a5/1", Q_WORD, COUNT);
        end
        drain();
    endtask

`ifdef REG4_DESER_PARITY_EN
    task automatic test_parity();
        sendWord(8'hA5, 1'b1, 1'b0, 1'b1);
        sendWord(8'h3C, 1'b1, 1'b0, 1'b0);
        checks++;
        if (Q_WORD !== 8'hA5 || PERR !== 1'b1) begin
            failures++; $display("FAIL perr_bad: Q_WORD=%h PERR=%b required a5/1", Q_WORD, PERR);
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (Q_WORD !== 8'h3C || PERR !== 1'b0) begin
            failures++; $display("FAIL perr_good: Q_WORD=%h PERR=%b required 3c/0", Q_WORD, PERR);
        end
        drain();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) == 0));
            checks++;
            if (VALID !== (mQ.size() > 0) || COUNT !== 3'(mQ.size()) || OVF !== mOvf) begin
                failures++;
                $display("FAIL random_ctl c=%0d: VALID=%b COUNT=%0d OVF=%b required %b/%0d/%b",
                         c, VALID, COUNT, OVF, (mQ.size() > 0), mQ.size(), mOvf);
            end
            if (mQ.size() > 0) begin
                checks++;
                if (Q_WORD !== mQ[0]) begin
                    failures++; $display("FAIL random_word c=%0d: Q_WORD=%h required %h", c, Q_WORD, mQ[0]);
                end
`ifdef REG4_DESER_PARITY_EN
                checks++;
                if (PERR !== mP[0]) begin
                    failures++; $display("FAIL random_perr c=%0d: PERR=%b required %b", c, PERR, mP[0]);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_dir_toggle();
        test_qualifier();
        test_overflow();
        test_full_push_pop();
        test_clr();
        test_reset_midword();
`ifdef REG4_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
